bce_sched: RTL and testbench

BCE_SCHED -- requirements
Module: bce_sched

---
 rtl/bce_pkg.sv | 24 ++
 rtl/bce_lsb_pick.sv | 19 +
 rtl/bce_sched.sv | 131 +++++++++++++
 tb/tb_bce_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bce_pkg.sv
// Shared definitions for the bit-column engine scheduler: state encoding,
// column geometry and a popcount helper.
package bce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SIGN  = 2'd1,
        ISSUE = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int NUM_COLS = 8;
    localparam int SIGN_COL = 7;

    function automatic logic [2:0] popcount7(input logic [6:0] m);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 7; i++) begin
            c = c + {2'b00, m[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bce_lsb_pick.sv
// Lowest-set-bit picker over the 7-bit magnitude-column mask.
module bce_lsb_pick (
    input  logic [6:0] mask,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = 3'd0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 6; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end
        end
        any = |mask;
    end

endmodule

// File: rtl/bce_sched.sv
// Bit-column scheduler: issues the sign column, then only the nonzero magnitude
// columns lowest-first. Optional skip counter enabled by BCE_SCHED_SKIP_CNT_EN.
module bce_sched
    import bce_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        ready,
    input  logic [63:0] act_in,
    input  logic [63:0] wcols_in,
    input  logic [6:0]  bitmap_in,
    input  logic        abort,
    output logic [63:0] activations,
    output logic [7:0]  weight_column,
    output logic        weight_sign_en,
    output logic [2:0]  shift_offset,
    output logic        col_valid,
    output logic        done
`ifdef BCE_SCHED_SKIP_CNT_EN
    ,
    output logic [15:0] skip_cnt
`endif
);

    state_t      state, state_nxt;
    logic [63:0] act_q;
    logic [63:0] wcols_q;
    logic [6:0]  mask_q;
    logic [6:0]  mask_rest;
    logic [2:0]  pick_idx;
    logic        pick_any;
    logic        accept;
    logic        kill;

    bce_lsb_pick u_pick (
        .mask (mask_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign accept    = (state == IDLE) && start && !abort;
    assign kill      = (state != IDLE) && abort;
    // Mask with its lowest set bit removed, i.e. what remains after this issue.
    assign mask_rest = mask_q & (mask_q - 7'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SIGN;
            SIGN:    state_nxt = (mask_q != 7'd0) ? ISSUE : FIN;
            ISSUE:   if (mask_rest == 7'd0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_q   <= '0;
            wcols_q <= '0;
            mask_q  <= '0;
        end else if (accept) begin
            act_q   <= act_in;
            wcols_q <= wcols_in;
            mask_q  <= bitmap_in;
        end else if (kill) begin
            mask_q  <= '0;
        end else if (state == ISSUE) begin
            mask_q  <= mask_rest;
        end
    end

    always_comb begin
        ready          = 1'b0;
        weight_column  = 8'd0;
        weight_sign_en = 1'b0;
        shift_offset   = 3'd0;
        col_valid      = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            SIGN: begin
                weight_sign_en = 1'b1;
                weight_column  = wcols_q[SIGN_COL*8 +: 8];
            end
            ISSUE: begin
                weight_column = wcols_q[{pick_idx, 3'b000} +: 8];
                shift_offset  = pick_idx;
                col_valid     = pick_any;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign activations = act_q;

`ifdef BCE_SCHED_SKIP_CNT_EN
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] skip_q;

    // Counts magnitude columns skipped because the bitmap marked them zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skip_q <= '0;
        end else if (accept) begin
            skip_q <= sat_add(skip_q, 3'd7 - popcount7(bitmap_in));
        end
    end

    assign skip_cnt = skip_q;
`endif

endmodule

// File: tb/tb_bce_sched.sv
// Directed testbench for bce_sched; skip counter checks run when
// BCE_SCHED_SKIP_CNT_EN is defined.
module tb_bce_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic [63:0] act_in = '0;
    logic [63:0] wcols_in = '0;
    logic [6:0]  bitmap_in = '0;
    logic        abort = 1'b0;
    logic [63:0] activations;
    logic [7:0]  weight_column;
    logic        weight_sign_en;
    logic [2:0]  shift_offset;
    logic        col_valid;
    logic        done;
`ifdef BCE_SCHED_SKIP_CNT_EN
    logic [15:0] skip_cnt;
`endif

    int vec_cnt = 0;
    int miss_cnt = 0;

    bce_sched dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .ready          (ready),
        .act_in         (act_in),
        .wcols_in       (wcols_in),
        .bitmap_in      (bitmap_in),
        .abort          (abort),
        .activations    (activations),
        .weight_column  (weight_column),
        .weight_sign_en (weight_sign_en),
        .shift_offset   (shift_offset),
        .col_valid      (col_valid),
        .done           (done)
`ifdef BCE_SCHED_SKIP_CNT_EN
        ,
        .skip_cnt       (skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, ready, 1);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".cv"}, col_valid, 0);
        chk({tag, ".sen"}, weight_sign_en, 0);
        chk({tag, ".wc"}, weight_column, 0);
        chk({tag, ".sh"}, shift_offset, 0);
    endtask

    logic [63:0] act_a, act_b;

    initial begin
        act_a = 64'h0102030405060708;
        act_b = 64'hCAFEF00DDEADBEEF;

        // Reset state
        #2;
        chk_idle("rst");
        chk("rst.act", activations, 0);
        step();
        rstn = 1'b1;
        step();

        // Sparse job: columns 0 and 2
        act_in    = act_a;
        wcols_in  = {8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'hF0, 8'hAA, 8'h0F};
        bitmap_in = 7'b0000101;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("j1.sign.ready", ready, 0);
        chk("j1.sign.sen", weight_sign_en, 1);
        chk("j1.sign.wc", weight_column, 8'h80);
        chk("j1.sign.sh", shift_offset, 0);
        chk("j1.sign.cv", col_valid, 0);
        chk("j1.sign.act", activations, act_a);
        step();
        chk("j1.i0.wc", weight_column, 8'h0F);
        chk("j1.i0.sh", shift_offset, 0);
        chk("j1.i0.cv", col_valid, 1);
        chk("j1.i0.sen", weight_sign_en, 0);
        step();
        chk("j1.i1.wc", weight_column, 8'hF0);
        chk("j1.i1.sh", shift_offset, 2);
        chk("j1.i1.cv", col_valid, 1);
        step();
        chk("j1.fin.done", done, 1);
        chk("j1.fin.cv", col_valid, 0);
        chk("j1.fin.wc", weight_column, 0);
        chk("j1.fin.act", activations, act_a);
        step();
        chk_idle("j1.end");

        // Empty bitmap: SIGN then FIN
        bitmap_in = 7'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("j2.sign.sen", weight_sign_en, 1);
        chk("j2.sign.cv", col_valid, 0);
        step();
        chk("j2.fin.done", done, 1);
        chk("j2.fin.cv", col_valid, 0);
        step();
        chk_idle("j2.end");

        // Dense bitmap: all seven magnitude columns in order
        wcols_in  = {8'h99, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        bitmap_in = 7'h7F;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("j3.sign.wc", weight_column, 8'h99);
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("j3.i%0d.wc", k), weight_column, 64'h10 + k);
            chk($sformatf("j3.i%0d.sh", k), shift_offset, k);
            chk($sformatf("j3.i%0d.cv", k), col_valid, 1);
            chk($sformatf("j3.i%0d.done", k), done, 0);
        end
        step();
        chk("j3.fin.done", done, 1);
        step();
        chk_idle("j3.end");

        // Abort in second ISSUE of a four-column job (columns 1,2,4,6)
        bitmap_in = 7'b1010110;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("j4.i0.sh", shift_offset, 1);
        step();
        chk("j4.i1.sh", shift_offset, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("j4.abort");
        step();
        chk("j4.after.done", done, 0);
        chk("j4.after.ready", ready, 1);

        // Abort together with start in IDLE is a no-op
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("j5.noop.ready", ready, 1);
        chk("j5.noop.sen", weight_sign_en, 0);

        // New start accepted after abort
        bitmap_in = 7'b0000001;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("j6.sign.sen", weight_sign_en, 1);
        step();
        chk("j6.i0.wc", weight_column, 8'h10);
        step();
        chk("j6.fin.done", done, 1);
        step();

        // Start held high across two jobs; busy-cycle inputs ignored
        act_in    = act_a;
        bitmap_in = 7'b0000001;
        start     = 1'b1;
        step();
        chk("j7.sign.sen", weight_sign_en, 1);
        act_in    = act_b;
        bitmap_in = 7'h7F;
        step();
        chk("j7.i0.sh", shift_offset, 0);
        chk("j7.i0.act", activations, act_a);
        step();
        chk("j7.fin.done", done, 1);
        chk("j7.fin.act", activations, act_a);
        step();
        chk("j7.gap.ready", ready, 1);
        step();
        start = 1'b0;
        chk("j8.sign.sen", weight_sign_en, 1);
        chk("j8.sign.act", activations, act_b);
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("j8.i%0d.sh", k), shift_offset, k);
        end
        step();
        chk("j8.fin.done", done, 1);
        step();
        chk_idle("j8.end");

        // Fresh reset so the skip counter starts from zero
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        step();
        bitmap_in = 7'h01;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        bitmap_in = 7'h00;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
`ifdef BCE_SCHED_SKIP_CNT_EN
        chk("skip.13", skip_cnt, 16'd13);
`endif

        // Reset mid-job discards the job
        bitmap_in = 7'h7F;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mid.cv", col_valid, 1);
        rstn = 1'b0;
        #1;
        chk_idle("mid.rst");
        chk("mid.act", activations, 0);
`ifdef BCE_SCHED_SKIP_CNT_EN
        chk("mid.skip", skip_cnt, 0);
`endif
        step();
        rstn = 1'b1;
        step();
        chk("mid.after.done", done, 0);
        chk("mid.after.ready", ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
